// File: rtl/opb_status_bank_simulink2ppc_if.sv
// OPB slave-side bus bundle for the status bank: master drives OPB_*, slave returns Sl_*.
// Latency: none, this is wiring only.
// Backpressure: none of its own; the slave paces each transfer with Sl_xferAck.
// Ports: OPB_ABus/OPB_DBus/OPB_BE use big-endian [0:n] numbering (bit 0 = MSB).
interface opb_status_bank_simulink2ppc_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_status_bank_simulink2ppc.sv
// Read-back bank of C_NUM_REGS 32-bit fabric status words on OPB, live/frozen/snapshot, optional sticky W1C.
// Latency: ack and read data one cycle after select+address hit; live input visible one edge after capture.
// Backpressure: none; every hit is acked after one cycle, then ack drops for a cycle (>=2 cycles per transfer).
// Ports: OPB_Clk/OPB_Rst (async, active-high) plain; opb = OPB slave bundle; user_data_in word k at [32k+31:32k].
module opb_status_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01060F00,
  parameter logic [31:0] C_HIGHADDR   = 32'h01060FFF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5",
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_STICKY     = 0
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  opb_status_bank_simulink2ppc_if.slave opb,
  input  logic [C_NUM_REGS*32-1:0] user_data_in
);

  // Informational parameters, kept so integrators can pass them unchanged.
  localparam string unused_family = C_FAMILY;
  localparam int    unused_widths = C_OPB_AWIDTH + C_OPB_DWIDTH;

  localparam logic [5:0] NUM_REGS_W = 6'(C_NUM_REGS);
  localparam logic [5:0] CTRL_IDX   = 6'h10;  // byte offset 0x40

  // Bus fields converted to numeric (bit 31 = MSB) order.
  logic [31:0] addr;
  logic [31:0] wdat;
  logic [3:0]  be_num;
  logic [31:0] wmask;
  logic [31:0] offset;
  logic [5:0]  word_idx;
  logic        hit, in_page, is_ctrl, is_word;
  logic        start, wr, rd;
  logic        ctrl_wr, snap, load;
  logic [31:0] rdat;
  logic        unused_bits;

  logic                     ack_q, ack_d;
  logic [31:0]              dbus_q, dbus_d;
  logic                     freeze_q, freeze_d;
  logic [C_NUM_REGS*32-1:0] words_q, words_d;

  always_comb begin
    addr   = '0;
    wdat   = '0;
    be_num = '0;
    for (int i = 0; i < 32; i++) begin
      addr[31-i] = opb.OPB_ABus[i];
      wdat[31-i] = opb.OPB_DBus[i];
    end
    for (int i = 0; i < 4; i++) begin
      be_num[3-i] = opb.OPB_BE[i];
    end
  end

  assign wmask = {{8{be_num[3]}}, {8{be_num[2]}}, {8{be_num[1]}}, {8{be_num[0]}}};

  // Full offset compare so a window wider than 256 bytes never aliases the map.
  assign hit      = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign offset   = addr - C_BASEADDR;
  assign in_page  = (offset[31:8] == 24'h0);
  assign word_idx = offset[7:2];
  assign is_ctrl  = in_page && (word_idx == CTRL_IDX);
  assign is_word  = in_page && (word_idx < NUM_REGS_W);

  // A transfer starts on the first hit cycle; ack_q masks the cycle after an ack.
  assign start = hit && !ack_q;
  assign wr    = start && !opb.OPB_RNW;
  assign rd    = start && opb.OPB_RNW;

  // Control bits live in the least significant byte, enabled by BE[3].
  assign ctrl_wr  = wr && is_ctrl && be_num[0];
  assign snap     = ctrl_wr && wdat[0];
  assign freeze_d = ctrl_wr ? wdat[1] : freeze_q;
  // Freeze is applied from the edge after it is written; a snapshot overrides it.
  assign load     = !freeze_q || snap;

  always_comb begin
    words_d = words_q;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      logic [31:0] src;
      logic [31:0] clr;
      src = user_data_in[32*k +: 32];
      clr = '0;
      if ((C_STICKY != 0) && wr && is_word && (word_idx == 6'(k))) begin
        clr = wdat & wmask;
      end
      if (C_STICKY != 0) begin
        // Clear first, then OR the new sample so a concurrent set wins.
        words_d[32*k +: 32] = (words_q[32*k +: 32] & ~clr) | (load ? src : 32'h0);
      end else if (load) begin
        words_d[32*k +: 32] = src;
      end
    end
  end

  always_comb begin
    rdat = '0;
    if (is_ctrl) begin
      rdat = {16'h0, 8'(C_NUM_REGS), 6'h0, freeze_q, 1'b0};
    end else if (is_word) begin
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (word_idx == 6'(k)) begin
          rdat = words_q[32*k +: 32];
        end
      end
    end
  end

  assign ack_d  = start;
  assign dbus_d = rd ? rdat : 32'h0;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      ack_q    <= 1'b0;
      dbus_q   <= '0;
      freeze_q <= 1'b0;
      words_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      dbus_q   <= dbus_d;
      freeze_q <= freeze_d;
      words_q  <= words_d;
    end
  end

  always_comb begin
    opb.Sl_DBus = '0;
    for (int i = 0; i < 32; i++) begin
      opb.Sl_DBus[i] = dbus_q[31-i];
    end
  end

  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  // seqAddr has no meaning for single-beat register access; byte lanes [1:0] are not decoded.
  assign unused_bits = ^{opb.OPB_seqAddr, offset[1:0]};

endmodule

// File: tb/tb_opb_status_bank_simulink2ppc.sv
module tb_opb_status_bank_simulink2ppc;
  localparam logic [31:0] BASE = 32'h01060F00;
  localparam logic [31:0] HIGH = 32'h01060FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] abus = '0;
  logic [31:0] wdbus = '0;
  logic [3:0]  be = '0;
  logic        rnw = 1'b0;
  logic        sel_live = 1'b0;
  logic        sel_stk = 1'b0;
  logic [127:0] ud_live = '0;
  logic [127:0] ud_stk = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] q_live[$];
  logic [31:0] q_stk[$];

  opb_status_bank_simulink2ppc_if if_live ();
  opb_status_bank_simulink2ppc_if if_stk ();

  assign if_live.OPB_ABus    = abus;
  assign if_live.OPB_DBus    = wdbus;
  assign if_live.OPB_BE      = be;
  assign if_live.OPB_RNW     = rnw;
  assign if_live.OPB_select  = sel_live;
  assign if_live.OPB_seqAddr = 1'b0;
  assign if_stk.OPB_ABus     = abus;
  assign if_stk.OPB_DBus     = wdbus;
  assign if_stk.OPB_BE       = be;
  assign if_stk.OPB_RNW      = rnw;
  assign if_stk.OPB_select   = sel_stk;
  assign if_stk.OPB_seqAddr  = 1'b0;

  opb_status_bank_simulink2ppc #(.C_NUM_REGS(4), .C_STICKY(0)) u_live (
    .OPB_Clk(clk), .OPB_Rst(rst), .opb(if_live.slave), .user_data_in(ud_live));
  opb_status_bank_simulink2ppc #(.C_NUM_REGS(4), .C_STICKY(1)) u_stk (
    .OPB_Clk(clk), .OPB_Rst(rst), .opb(if_stk.slave), .user_data_in(ud_stk));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per ack, and the bus must be idle otherwise.
  always @(negedge clk) begin
    logic [31:0] e;
    if (if_live.Sl_xferAck === 1'b1) begin
      if (q_live.size() == 0) chk("live_unexpected_ack", 32'h1, 32'h0);
      else begin e = q_live.pop_front(); chk("live_rdata", if_live.Sl_DBus, e); end
    end else if (if_live.Sl_DBus !== 32'h0) chk("live_idle_bus", if_live.Sl_DBus, 32'h0);
    if (if_stk.Sl_xferAck === 1'b1) begin
      if (q_stk.size() == 0) chk("stk_unexpected_ack", 32'h1, 32'h0);
      else begin e = q_stk.pop_front(); chk("stk_rdata", if_stk.Sl_DBus, e); end
    end else if (if_stk.Sl_DBus !== 32'h0) chk("stk_idle_bus", if_stk.Sl_DBus, 32'h0);
  end

  function automatic logic get_ack(input bit stk);
    return stk ? if_stk.Sl_xferAck : if_live.Sl_xferAck;
  endfunction

  // One OPB transfer; writes expect Sl_DBus = 0 during their ack.
  task automatic xfer(input bit stk, input logic [31:0] off, input bit rd,
                      input logic [3:0] be_i, input logic [31:0] wd, input logic [31:0] exp);
    int cyc;
    if (stk) q_stk.push_back(rd ? exp : 32'h0);
    else     q_live.push_back(rd ? exp : 32'h0);
    abus = BASE + off; rnw = rd; be = be_i; wdbus = wd;
    if (stk) sel_stk = 1'b1; else sel_live = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (get_ack(stk) !== 1'b1 && cyc < 6);
    if (get_ack(stk) !== 1'b1) begin
      chk("ack_timeout", 32'h0, 32'h1);
      if (stk) void'(q_stk.pop_back()); else void'(q_live.pop_back());
    end else begin
      chk("ack_latency", 32'(cyc), 32'd1);
      @(posedge clk); #1;
      chk("ack_drops_with_select_high", 32'(get_ack(stk)), 32'h0);
    end
    sel_stk = 1'b0; sel_live = 1'b0; rnw = 1'b0; be = 4'h0; wdbus = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(if_live.Sl_xferAck), 32'h0);
    chk("reset_dbus", if_live.Sl_DBus, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset asserted while a control read is acking.
    q_live.push_back(32'h00000400);
    abus = BASE + 32'h40; rnw = 1'b1; be = 4'hF; sel_live = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1; #1;
    chk("rst_mid_read_ack", 32'(if_live.Sl_xferAck), 32'h0);
    chk("rst_mid_read_dbus", if_live.Sl_DBus, 32'h0);
    sel_live = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    xfer(0, 32'h40, 1, 4'hF, 0, 32'h00000400);

    // Live read.
    ud_live[64 +: 32] = 32'hDEADBEEF;
    @(posedge clk); #1;
    xfer(0, 32'h08, 1, 4'hF, 0, 32'hDEADBEEF);

    // Freeze: old values survive input changes.
    ud_live = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    @(posedge clk); #1;
    xfer(0, 32'h40, 0, 4'hF, 32'h2, 0);
    ud_live = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
    repeat (2) @(posedge clk); #1;
    xfer(0, 32'h00, 1, 4'hF, 0, 32'hA1);
    xfer(0, 32'h0C, 1, 4'hF, 0, 32'hA4);
    xfer(0, 32'h40, 1, 4'hF, 0, 32'h00000402);

    // Snapshot while frozen, then inputs move again.
    ud_live = {32'h44, 32'h33, 32'h22, 32'h11};
    xfer(0, 32'h40, 0, 4'hF, 32'h3, 0);
    ud_live = {32'hC4, 32'hC3, 32'hC2, 32'hC1};
    xfer(0, 32'h00, 1, 4'hF, 0, 32'h11);
    xfer(0, 32'h04, 1, 4'hF, 0, 32'h22);
    xfer(0, 32'h08, 1, 4'hF, 0, 32'h33);
    xfer(0, 32'h0C, 1, 4'hF, 0, 32'h44);

    // Non-sticky write is ignored; unfreeze resumes live sampling.
    xfer(0, 32'h04, 0, 4'hF, 32'hFFFFFFFF, 0);
    xfer(0, 32'h04, 1, 4'hF, 0, 32'h22);
    xfer(0, 32'h40, 0, 4'hF, 32'h0, 0);
    xfer(0, 32'h04, 1, 4'hF, 0, 32'hC2);

    // Unmapped offset in window.
    xfer(0, 32'h30, 1, 4'hF, 0, 32'h0);

    // Out of window: no ack for 16 cycles.
    abus = HIGH + 32'd4; rnw = 1'b1; be = 4'hF; sel_live = 1'b1;
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (if_live.Sl_xferAck !== 1'b0 || if_live.Sl_DBus !== 32'h0) acks++;
    end
    chk("out_of_window_quiet_cycles", 32'(acks), 32'h0);
    sel_live = 1'b0;

    // Sticky: one-cycle pulse on bit 5 is held.
    ud_stk[31:0] = 32'h20;
    @(posedge clk); #1;
    ud_stk[31:0] = 32'h0;
    repeat (2) @(posedge clk); #1;
    xfer(1, 32'h00, 1, 4'hF, 0, 32'h20);
    xfer(1, 32'h00, 0, 4'hF, 32'h20, 0);
    xfer(1, 32'h00, 1, 4'hF, 0, 32'h0);

    // Clear while the input is still set: set wins.
    ud_stk[31:0] = 32'h20;
    @(posedge clk); #1;
    xfer(1, 32'h00, 0, 4'hF, 32'h20, 0);
    xfer(1, 32'h00, 1, 4'hF, 0, 32'h20);
    ud_stk[31:0] = 32'h0;
    xfer(1, 32'h00, 0, 4'hF, 32'h20, 0);
    xfer(1, 32'h00, 1, 4'hF, 0, 32'h0);

    // Byte-enabled W1C: only DBus[8:15] lane is cleared.
    ud_stk[63:32] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    ud_stk[63:32] = 32'h0;
    xfer(1, 32'h04, 0, 4'b0100, 32'hFFFFFFFF, 0);
    xfer(1, 32'h04, 1, 4'hF, 0, 32'hFF00FFFF);
    xfer(1, 32'h40, 1, 4'hF, 0, 32'h00000400);

    repeat (4) @(posedge clk); #1;
    chk("live_queue_drained", 32'(q_live.size()), 32'h0);
    chk("stk_queue_drained", 32'(q_stk.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/opb_status_bank_simulink2ppc.md
# opb_status_bank_simulink2ppc

Multi-channel read-back status bank on the OPB bus. It is the parametrised successor to the single-word simulink-to-PPC status register. It exposes `C_NUM_REGS` 32-bit status words from the fabric to the PowerPC. Each word can be sampled live or frozen by an atomic snapshot, and can optionally be sticky with write-1-to-clear. The bank sits on the OPB next to the other software registers and runs entirely in the OPB clock domain; the fabric drives `user_data_in` already synchronous to `OPB_Clk`.

## Interface
- `C_BASEADDR`, default 32'h01060F00: window base address; must be 256-byte aligned.
- `C_HIGHADDR`, default 32'h01060FFF: window top address; the window is at least 256 bytes.
- `C_OPB_AWIDTH`, default 32: OPB address width.
- `C_OPB_DWIDTH`, default 32: OPB data width.
- `C_FAMILY`, default "virtex5": target family (informational).
- `C_NUM_REGS`, default 4: number of status words, 1..16.
- `C_STICKY`, default 0: 1 = all words OR-accumulate and are write-1-to-clear.
- `OPB_Clk`  in  1: the single clock.
- `OPB_Rst`  in  1: asynchronous, active-high reset.
- `OPB_ABus`  in  [0:31]: address.
- `OPB_BE`  in  [0:3]: byte enables; `BE[0]` covers `DBus[0:7]`.
- `OPB_DBus`  in  [0:31]: write data.
- `OPB_RNW`  in  1: 1 = read.
- `OPB_select`  in  1: transfer request.
- `OPB_seqAddr`  in  1: ignored.
- `Sl_DBus`  out  [0:31]: read data; zero when not acking.
- `Sl_xferAck`  out  1: transfer acknowledge.
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup`  out  1 each: tied 0.
- `user_data_in`  in  C_NUM_REGS*32: word k is bits [32k+31:32k].

## Operation
- **Bit order:** `Sl_DBus[i]` = value bit 31-i, so numeric values are preserved.
- **Hit:** `OPB_select` asserted and `C_BASEADDR` ≤ `OPB_ABus` ≤ `C_HIGHADDR`. Word index is `OPB_ABus[24:29]`, i.e. byte offset [7:2].
- **Address map:**
  - Offsets 0x00..4*(C_NUM_REGS-1): status words. Reads return the held value. Writes apply a W1C clear only when `C_STICKY`=1; otherwise they are ignored.
  - Offset 0x40: control register.
    - Write bit 0 (`BE[3]`): snapshot request, self-clearing.
    - Write bit 1 (`BE[3]`): freeze.
    - Read: bit 1 = freeze, bits [15:8] = `C_NUM_REGS`, all other bits 0.
  - Any other offset in the window: acked, reads 0, writes ignored.
- **Update rule for word k, evaluated each edge:**
  - `src` = live input word when (freeze=0 or snapshot pulse on this edge); otherwise no load.
  - Non-sticky: `reg` <= `src` on load; otherwise hold.
  - Sticky: `reg` <= (`reg` & ~`clr`) | (load ? `src` : 0). Here `clr` is the byte-enabled write data on a W1C commit this edge, else 0. A set on the same edge as a clear wins.
- **Snapshot:** loads all words from the same edge, so the capture is atomic across channels.
- **Writes:** byte-enabled, with bytes outside `BE` untouched.

## Timing
- **Handshake:**
  - `ack` <= hit & ~`ack`. `Sl_xferAck` is high for exactly one cycle, on the cycle after hit is first seen.
  - `Sl_xferAck` is low on the following cycle even if `OPB_select` stays high.
  - Back-to-back transfers therefore take at least 2 cycles each.
- **Reads:**
  - `Sl_DBus` is registered. It carries the word value as held before the ack edge, during the ack cycle only, and is 0 otherwise.
  - A W1C on the same word is not visible until a later read.
- **Writes:** commit on the edge that raises `Sl_xferAck`. The snapshot pulse, freeze change and W1C clear all take effect on that edge.
- **Live latency:** input at edge t appears in the register after edge t and is readable by an ack raised at edge t+1 or later.
- **Freeze:** the freeze=1 write edge itself still loads live data. From the next edge onward, words hold.
- **Reset (async):**
  - All status words and freeze are 0; `Sl_xferAck`=0 and `Sl_DBus`=0.
  - A transfer in flight is dropped with no ack, and the master times out.
  - On deassert, the bank resumes in live mode.

## Test plan
- **Reset and ID:** assert `OPB_Rst` mid-read.
  - `Sl_xferAck`/`Sl_DBus` drop to 0 immediately.
  - A read of 0x40 afterwards returns 0x00000400 (C_NUM_REGS=4, freeze=0).
- **Live read:** drive word 2 = 0xDEADBEEF and read offset 0x08.
  - Ack comes one cycle after select and lasts one cycle.
  - `Sl_DBus` = 0xDEADBEEF; bus is 0 on surrounding cycles.
- **Freeze and snapshot:**
  - Write 0x2 to 0x40, then change inputs; reads return the old values.
  - Write 0x3 with words = 0x11/0x22/0x33/0x44; all four read back exactly these values.
- **Sticky (C_STICKY=1):**
  - Pulse input bit 5 for one cycle, then read; 0x20 is held.
  - Write 0x20 to clear, then read; result is 0.
  - Clear with input bit 5 held high; bit remains 1.
- **Byte enables / unmapped:**
  - Sticky word 0xFFFFFFFF, W1C 0xFFFFFFFF with `BE`=0100; readback 0xFF00FFFF.
  - Read 0x30 with C_NUM_REGS=4; returns 0 with ack.
- **Out-of-window:** select with `OPB_ABus` = `C_HIGHADDR`+4.
  - No ack for 16 cycles, and `Sl_DBus` stays 0.
